fpa_arbiter: RTL and testbench

Sequencing and sharing controller for the half-precision floating-point adder `fpa` (combinational, ports `a`, `b`, `out`). It accepts add requests from two independent requesters over valid/ready handshakes and grants them round-robin. It registers the winning operands, holds them on the shared `fpa` instance for a fixed settle time, then captures and returns the sum tagged with the requester id. It also handles the zero-operand and overflow cases that `fpa` does not cover.

---
 rtl/fpa_pkg.sv | 30 +++
 rtl/fpa.sv | 67 ++++++
 rtl/fpa_arbiter.sv | 124 ++++++++++++
 tb/tb_fpa_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
// Shared types and constants for the half-precision adder and its arbiter.
package fpa_pkg;

  localparam int         HALF_W  = 16;
  localparam int         EXP_HI  = 14;
  localparam int         EXP_LO  = 10;
  localparam logic [4:0] EXP_INF = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Result source chosen at transfer time: adder output or one operand passed through.
  typedef enum logic [1:0] {
    ZS_FPA = 2'd0,
    ZS_B   = 2'd1,
    ZS_A   = 2'd2
  } zsel_t;

  // Operands arrive without their sign bit so +0 and -0 are treated alike.
  function automatic zsel_t zero_sel(input logic [HALF_W-2:0] mag_a,
                                     input logic [HALF_W-2:0] mag_b);
    if (mag_a == '0) return ZS_B;
    if (mag_b == '0) return ZS_A;
    return ZS_FPA;
  endfunction

endpackage

// File: rtl/fpa.sv
// Combinational half-precision adder, truncating, no zero/inf/NaN special cases.
// Zero latency; no flow control (pure function of a and b).
module fpa
  import fpa_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [HALF_W-1:0] out
);

  logic [HALF_W-1:0] x;
  logic [HALF_W-1:0] y;
  logic [5:0]        ex;
  logic [5:0]        ey;
  logic [5:0]        ed;
  logic [5:0]        er;
  logic [13:0]       mx;
  logic [13:0]       my_raw;
  logic [13:0]       my;
  logic [13:0]       norm;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic              hit;
  logic [9:0]        frac;
  logic              unused_bits;

  always_comb begin
    x      = (a[14:0] >= b[14:0]) ? a : b;
    y      = (a[14:0] >= b[14:0]) ? b : a;
    ex     = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
    ey     = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
    // Hidden bit plus three guard bits below the fraction.
    mx     = {x[14:10] != 5'd0, x[9:0], 3'b000};
    my_raw = {y[14:10] != 5'd0, y[9:0], 3'b000};
    ed     = ex - ey;
    my     = (ed > 6'd13) ? 14'd0 : (my_raw >> ed);

    if (x[15] == y[15]) sum = {1'b0, mx} + {1'b0, my};
    else                sum = {1'b0, mx} - {1'b0, my};

    lz  = 4'd0;
    hit = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!hit && sum[i]) begin
        hit = 1'b1;
        lz  = 4'(13 - i);
      end
    end
    norm = sum[13:0] << lz;

    er   = 6'd0;
    frac = 10'd0;
    if (sum[14]) begin
      er   = ex + 6'd1;
      frac = sum[13:4];
    end else if (hit && (ex > {2'b00, lz})) begin
      er   = ex - {2'b00, lz};
      frac = norm[12:3];
    end

    // Exact cancellation and underflow both flush to +0.
    out = (er == 6'd0) ? '0 : {x[15], er[4:0], frac};
  end

  assign unused_bits = ^{er[5], norm[13], norm[2:0]};

endmodule

// File: rtl/fpa_arbiter.sv
// Round-robin sharing of one fpa adder between two requesters; rsp_valid rises LAT edges after transfer.
// One operation in flight; rsp_ready low holds the result and blocks every grant.
module fpa_arbiter
  import fpa_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [HALF_W-1:0] req0_a,
  input  logic [HALF_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [HALF_W-1:0] req1_a,
  input  logic [HALF_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [HALF_W-1:0] rsp_data,
  output logic              rsp_inf,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic              prio;
  logic              grant;
  logic              any_req;
  logic              xfer;
  logic [3:0]        cnt;
  logic [HALF_W-1:0] op_a;
  logic [HALF_W-1:0] op_b;
  logic              op_id;
  logic [HALF_W-1:0] sel_a;
  logic [HALF_W-1:0] sel_b;
  logic [HALF_W-1:0] fpa_out;
  logic [HALF_W-1:0] res;
  zsel_t             zsel;
  zsel_t             zsel_nxt;

  fpa u_fpa (
    .a   (op_a),
    .b   (op_b),
    .out (fpa_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    any_req    = req0_valid | req1_valid;
    grant      = (req0_valid && req1_valid) ? prio : req1_valid;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xfer       = 1'b0;
    rsp_valid  = (state == ST_RESP);
    busy       = (state != ST_IDLE);

    unique case (state)
      ST_IDLE: begin
        req0_ready = any_req && !grant;
        req1_ready = any_req && grant;
        xfer       = any_req;
        if (xfer) state_nxt = ST_WAIT;
      end
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_a    = grant ? req1_a : req0_a;
    sel_b    = grant ? req1_b : req0_b;
    zsel_nxt = zero_sel(sel_a[HALF_W-2:0], sel_b[HALF_W-2:0]);
  end

  always_comb begin
    res = fpa_out;
    case (zsel)
      ZS_B:    res = op_b;
      ZS_A:    res = op_a;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio     <= 1'b0;
      cnt      <= 4'd0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= 1'b0;
      zsel     <= ZS_FPA;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      rsp_inf  <= 1'b0;
    end else begin
      if (xfer) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        op_id <= grant;
        zsel  <= zsel_nxt;
        prio  <= ~grant;
        cnt   <= 4'(LAT - 1);
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      // Operands have been stable on the adder for LAT cycles at this point.
      if (state == ST_WAIT && cnt == 4'd0) begin
        rsp_data <= res;
        rsp_id   <= op_id;
        rsp_inf  <= (res[EXP_HI:EXP_LO] == EXP_INF);
      end
    end
  end

endmodule

// File: tb/tb_fpa_arbiter.sv
// Directed bench for fpa_arbiter with a response scoreboard.
module tb_fpa_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_inf;
  logic        busy;

  typedef struct {
    logic        id;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        inf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  fpa_arbiter #(.LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_inf    (rsp_inf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [15:0] obs,
                         input logic [15:0] lo, input logic [15:0] hi);
    n_checks++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected range %0h..%0h", tag, obs, lo, hi);
    end
  endtask

  task automatic push_exp(input logic id, input logic [15:0] lo,
                          input logic [15:0] hi, input logic inf);
    exp_t e;
    e.id  = id;
    e.lo  = lo;
    e.hi  = hi;
    e.inf = inf;
    sb.push_back(e);
  endtask

  task automatic check_rsp();
    exp_t e;
    chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk_rng("rsp_data", rsp_data, e.lo, e.hi);
      chk("rsp_inf", 32'(rsp_inf), 32'(e.inf));
    end
  endtask

  // Handshake is judged on the values presented to the coming rising edge.
  task automatic tick();
    if (rst_n && rsp_valid && rsp_ready) check_rsp();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] lo, input logic [15:0] hi, input logic inf,
                        input logic push, output int waited);
    logic rdy;
    waited = 0;
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && waited < 30) begin
      tick();
      #1;
      waited++;
      rdy = id ? req1_ready : req0_ready;
    end
    chk("grant_seen", 32'(rdy), 32'd1);
    if (push) push_exp(id, lo, hi, inf);
    tick();
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int          w;
    int          nx;
    int          last;
    logic [15:0] hd;
    logic        hid;
    logic        hinf;

    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_inf", 32'(rsp_inf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic add 1.0 + 1.0 with latency check.
    do_req(1'b0, 16'h3C00, 16'h3C00, 16'h4000, 16'h4000, 1'b0, 1'b1, w);
    chk("basic_ready_immediate", 32'(w), 32'd0);
    tick();
    chk("basic_valid_edge1", 32'(rsp_valid), 32'd0);
    tick();
    chk("basic_valid_edge2", 32'(rsp_valid), 32'd1);
    drain();

    // Real operands from requester 1.
    do_req(1'b1, 16'h2C4D, 16'h3DCC, 16'h3E10, 16'h3E12, 1'b0, 1'b1, w);
    drain();

    // Round-robin with both requesters continuously valid.
    push_exp(1'b0, 16'h4000, 16'h4000, 1'b0);
    push_exp(1'b1, 16'h3C00, 16'h3C00, 1'b0);
    push_exp(1'b0, 16'h4000, 16'h4000, 1'b0);
    push_exp(1'b1, 16'h3C00, 16'h3C00, 1'b0);
    req0_a = 16'h3C00; req0_b = 16'h3C00;
    req1_a = 16'h0000; req1_b = 16'h3C00;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    nx   = 0;
    last = 0;
    for (int t = 0; t < 40 && nx < 4; t++) begin
      #1;
      chk("rr_ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_ready || req1_ready) begin
        chk("rr_grant_order", 32'(req1_ready), 32'(nx % 2));
        if (nx > 0) chk("rr_period", 32'(cyc - last), 32'(LAT + 2));
        last = cyc;
        nx++;
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_transfers", 32'(nx), 32'd4);
    drain();

    // Zero-operand bypass.
    do_req(1'b0, 16'h0000, 16'h3DCC, 16'h3DCC, 16'h3DCC, 1'b0, 1'b1, w);
    drain();
    do_req(1'b0, 16'h8000, 16'hBC00, 16'hBC00, 16'hBC00, 1'b0, 1'b1, w);
    drain();
    do_req(1'b0, 16'h3C00, 16'h8000, 16'h3C00, 16'h3C00, 1'b0, 1'b1, w);
    drain();

    // Overflow held under backpressure while requester 1 waits.
    rsp_ready = 1'b0;
    do_req(1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00, 16'h7FFF, 1'b1, 1'b1, w);
    req1_a = 16'h3C00; req1_b = 16'h3C00; req1_valid = 1'b1;
    nx = 0;
    while (!rsp_valid && nx < 20) begin
      #1;
      chk("bp_req1_blocked_wait", 32'(req1_ready), 32'd0);
      tick();
      nx++;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_exp_field", 32'(rsp_data[14:10]), 32'h1F);
    hd   = rsp_data;
    hid  = rsp_id;
    hinf = rsp_inf;
    repeat (5) begin
      tick();
      #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(rsp_data), 32'(hd));
      chk("bp_hold_id", 32'(rsp_id), 32'(hid));
      chk("bp_hold_inf", 32'(rsp_inf), 32'(hinf));
      chk("bp_req1_blocked", 32'(req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_idle_after_ready", 32'(busy), 32'd0);
    chk("bp_req1_granted", 32'(req1_ready), 32'd1);
    push_exp(1'b1, 16'h4000, 16'h4000, 1'b0);
    tick();
    req1_valid = 1'b0;
    drain();

    // Reset during WAIT drops the operation and clears the pointer.
    do_req(1'b0, 16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 1'b0, 1'b0, w);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    repeat (6) tick();
    chk("mid_rst_stays_idle", 32'(busy), 32'd0);
    req0_a = 16'h3C00; req0_b = 16'h3C00;
    req1_a = 16'h0000; req1_b = 16'h3C00;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("post_rst_req0_first", 32'(req0_ready), 32'd1);
    chk("post_rst_req1_wait", 32'(req1_ready), 32'd0);
    push_exp(1'b0, 16'h4000, 16'h4000, 1'b0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
